ws2812b_frame_streamer: RTL and testbench

- Parametrised WS2812B chain driver. Accepts a full frame of per-pixel on/off bits for R, G and B, plus per-channel 8-bit brightness, over a valid/ready handshake.
- Latches the frame into shadow registers, then serialises NUM_PIXELS x 24 bits with internally generated bit timing, followed by the latch/reset gap.
- Replaces the separate controller + ws2812b + external shift register arrangement. Sits between the pattern generators (e.g. game_of_life instances) and the LED data pin.

---
 rtl/ws2812b_frame_streamer.sv | 237 +++++++++++++++++++++++
 tb/tb_ws2812b_frame_streamer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812b_frame_streamer.sv
// ws2812b_frame_streamer
//
// Drives a chain of WS2812B LEDs from a whole frame of per-pixel on/off
// bits plus one 8-bit brightness level per colour channel. A frame is taken
// over a valid/ready handshake and copied into shadow registers, so the
// pattern sources may change their outputs while the frame is on the wire.
// Each pixel is sent as a 24-bit word, MSB first. Every bit lasts T_BIT
// cycles and is high for T1H (1 bit) or T0H (0 bit) cycles. The last pixel
// is followed by a T_RESET cycle low gap, which latches the chain.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   frame_valid  frame bits and brightness are valid
//   frame_ready  streamer is idle and can accept a frame
//   red_bits     bit i = pixel i red on   (likewise green_bits, blue_bits)
//   bright_r/g/b level sent for a channel that is on (8'h00 when off)
//   ws2812b_out  registered serial data to the first LED
//   busy         high from frame acceptance until frame_done
//   pixel_idx    pixel currently on the wire, 0 when not sending
//   frame_done   one-cycle pulse at the end of the latch gap
//
// Timing: the output is registered, so the wire shows each control cycle one
// clock later. Accept edge -> LOAD (1 cycle) -> first high on the wire two
// edges after acceptance. frame_done rises exactly T_RESET cycles after the
// wire goes low for the gap, and frame_ready is high in that same cycle, so
// the next frame can be accepted on the edge that ends the pulse.
module ws2812b_frame_streamer #(
   parameter int NUM_PIXELS  = 64,
   parameter int T0H         = 4,
   parameter int T1H         = 8,
   parameter int T_BIT       = 15,
   parameter int T_RESET     = 3600,
   parameter int COLOR_ORDER = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  frame_valid,
   output logic                  frame_ready,
   input  logic [NUM_PIXELS-1:0] red_bits,
   input  logic [NUM_PIXELS-1:0] green_bits,
   input  logic [NUM_PIXELS-1:0] blue_bits,
   input  logic [7:0]            bright_r,
   input  logic [7:0]            bright_g,
   input  logic [7:0]            bright_b,
   output logic                  ws2812b_out,
   output logic                  busy,
   output logic [((NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1)-1:0] pixel_idx,
   output logic                  frame_done
);

   localparam int PIX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam int CYC_W = (T_BIT > 1) ? $clog2(T_BIT) : 1;
   localparam int GAP_W = (T_RESET > 0) ? $clog2(T_RESET + 1) : 1;

   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(T_BIT - 1);
   localparam logic [CYC_W-1:0] T0H_C    = CYC_W'(T0H);
   localparam logic [CYC_W-1:0] T1H_C    = CYC_W'(T1H);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(T_RESET);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NUM_PIXELS - 1);
   localparam logic [4:0]       BIT_LAST = 5'd23;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_GAP
   } state_t;

   state_t                  state_reg, state_next;
   logic [23:0]             shift_reg, shift_next;
   logic [4:0]              bit_cnt_reg, bit_cnt_next;
   logic [CYC_W-1:0]        cyc_cnt_reg, cyc_cnt_next;
   logic [GAP_W-1:0]        gap_cnt_reg, gap_cnt_next;
   logic [PIX_W-1:0]        pix_cnt_reg, pix_cnt_next;
   logic [PIX_W-1:0]        pixel_idx_reg, pixel_idx_next;
   logic [NUM_PIXELS-1:0]   red_sh_reg, red_sh_next;
   logic [NUM_PIXELS-1:0]   green_sh_reg, green_sh_next;
   logic [NUM_PIXELS-1:0]   blue_sh_reg, blue_sh_next;
   logic [7:0]              br_r_reg, br_r_next;
   logic [7:0]              br_g_reg, br_g_next;
   logic [7:0]              br_b_reg, br_b_next;
   logic                    out_reg, out_next;
   logic                    busy_reg, busy_next;
   logic                    done_reg, done_next;

   // Wire word for every pixel, built from the shadow copy of the frame.
   logic [23:0]             pix_word [NUM_PIXELS];
   logic [PIX_W-1:0]        load_idx;
   logic [CYC_W-1:0]        high_time;

   generate
      for (genvar gi = 0; gi < NUM_PIXELS; gi++) begin : g_pix
         logic [7:0] r_byte;
         logic [7:0] g_byte;
         logic [7:0] b_byte;
         assign r_byte = red_sh_reg[gi]   ? br_r_reg : 8'h00;
         assign g_byte = green_sh_reg[gi] ? br_g_reg : 8'h00;
         assign b_byte = blue_sh_reg[gi]  ? br_b_reg : 8'h00;
         assign pix_word[gi] = (COLOR_ORDER == 0) ? {g_byte, r_byte, b_byte}
                                                  : {r_byte, g_byte, b_byte};
      end
   endgenerate

   // LOAD fetches pixel 0; during SEND the next pixel is fetched on the last
   // cycle of bit 23 so that pixels follow each other without a gap.
   assign load_idx  = (state_reg == ST_LOAD) ? '0 : pix_cnt_reg + PIX_W'(1);
   assign high_time = shift_reg[23] ? T1H_C : T0H_C;

   always_comb begin
      state_next     = state_reg;
      shift_next     = shift_reg;
      bit_cnt_next   = bit_cnt_reg;
      cyc_cnt_next   = cyc_cnt_reg;
      gap_cnt_next   = gap_cnt_reg;
      pix_cnt_next   = pix_cnt_reg;
      red_sh_next    = red_sh_reg;
      green_sh_next  = green_sh_reg;
      blue_sh_next   = blue_sh_reg;
      br_r_next      = br_r_reg;
      br_g_next      = br_g_reg;
      br_b_next      = br_b_reg;
      busy_next      = busy_reg;
      out_next       = 1'b0;
      done_next      = 1'b0;
      pixel_idx_next = '0;

      case (state_reg)
         ST_IDLE: begin
            // frame_ready is high throughout IDLE
            if (frame_valid) begin
               red_sh_next   = red_bits;
               green_sh_next = green_bits;
               blue_sh_next  = blue_bits;
               br_r_next     = bright_r;
               br_g_next     = bright_g;
               br_b_next     = bright_b;
               busy_next     = 1'b1;
               state_next    = ST_LOAD;
            end
         end

         ST_LOAD: begin
            shift_next   = pix_word[load_idx];
            bit_cnt_next = '0;
            cyc_cnt_next = '0;
            pix_cnt_next = '0;
            state_next   = ST_SEND;
         end

         ST_SEND: begin
            out_next       = (cyc_cnt_reg < high_time);
            pixel_idx_next = pix_cnt_reg;
            if (cyc_cnt_reg == CYC_LAST) begin
               cyc_cnt_next = '0;
               if (bit_cnt_reg == BIT_LAST) begin
                  if (pix_cnt_reg == PIX_LAST) begin
                     gap_cnt_next = '0;
                     state_next   = ST_GAP;
                  end else begin
                     shift_next   = pix_word[load_idx];
                     bit_cnt_next = '0;
                     pix_cnt_next = load_idx;
                  end
               end else begin
                  shift_next   = {shift_reg[22:0], 1'b0};
                  bit_cnt_next = bit_cnt_reg + 5'd1;
               end
            end else begin
               cyc_cnt_next = cyc_cnt_reg + CYC_W'(1);
            end
         end

         ST_GAP: begin
            // One cycle longer than T_RESET because the wire lags the
            // state by a clock; this lines frame_done up with the end of
            // T_RESET low cycles on the wire.
            if (gap_cnt_reg == GAP_LAST) begin
               done_next  = 1'b1;
               busy_next  = 1'b0;
               state_next = ST_IDLE;
            end else begin
               gap_cnt_next = gap_cnt_reg + GAP_W'(1);
            end
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         shift_reg     <= '0;
         bit_cnt_reg   <= '0;
         cyc_cnt_reg   <= '0;
         gap_cnt_reg   <= '0;
         pix_cnt_reg   <= '0;
         pixel_idx_reg <= '0;
         red_sh_reg    <= '0;
         green_sh_reg  <= '0;
         blue_sh_reg   <= '0;
         br_r_reg      <= '0;
         br_g_reg      <= '0;
         br_b_reg      <= '0;
         out_reg       <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         shift_reg     <= shift_next;
         bit_cnt_reg   <= bit_cnt_next;
         cyc_cnt_reg   <= cyc_cnt_next;
         gap_cnt_reg   <= gap_cnt_next;
         pix_cnt_reg   <= pix_cnt_next;
         pixel_idx_reg <= pixel_idx_next;
         red_sh_reg    <= red_sh_next;
         green_sh_reg  <= green_sh_next;
         blue_sh_reg   <= blue_sh_next;
         br_r_reg      <= br_r_next;
         br_g_reg      <= br_g_next;
         br_b_reg      <= br_b_next;
         out_reg       <= out_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
      end
   end

   assign frame_ready = (state_reg == ST_IDLE);
   assign ws2812b_out = out_reg;
   assign busy        = busy_reg;
   assign pixel_idx   = pixel_idx_reg;
   assign frame_done  = done_reg;

endmodule

// File: tb/tb_ws2812b_frame_streamer.sv
// Bench for ws2812b_frame_streamer. Two instances share the stimulus, one
// with GRB wire order and one with RGB. The expected wire waveform is
// rebuilt for every frame from the colour bits and brightness values.
module tb_ws2812b_frame_streamer;

   localparam int NP   = 2;
   localparam int T0H  = 2;
   localparam int T1H  = 4;
   localparam int TB   = 6;
   localparam int TR   = 10;
   localparam int PIXC = 24 * TB;
   localparam int DATA = NP * PIXC;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          frame_valid;
   logic [NP-1:0] red_bits, green_bits, blue_bits;
   logic [7:0]    bright_r, bright_g, bright_b;

   logic          ready0, out0, busy0, done0;
   logic          ready1, out1, busy1, done1;
   logic [0:0]    pidx0, pidx1;

   int            total = 0;
   int            bad   = 0;

   // expected wire level per data cycle, [0] = GRB instance, [1] = RGB
   bit            exp_wave [2][DATA];

   // values placed on the inputs half way through a frame
   logic [NP-1:0] nxt_r, nxt_g, nxt_b;
   logic [7:0]    nxt_br, nxt_bg, nxt_bb;

   always #5 clk = ~clk;

   ws2812b_frame_streamer #(
      .NUM_PIXELS(NP), .T0H(T0H), .T1H(T1H), .T_BIT(TB), .T_RESET(TR),
      .COLOR_ORDER(0)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid),
      .frame_ready(ready0), .red_bits(red_bits), .green_bits(green_bits),
      .blue_bits(blue_bits), .bright_r(bright_r), .bright_g(bright_g),
      .bright_b(bright_b), .ws2812b_out(out0), .busy(busy0),
      .pixel_idx(pidx0), .frame_done(done0)
   );

   ws2812b_frame_streamer #(
      .NUM_PIXELS(NP), .T0H(T0H), .T1H(T1H), .T_BIT(TB), .T_RESET(TR),
      .COLOR_ORDER(1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid),
      .frame_ready(ready1), .red_bits(red_bits), .green_bits(green_bits),
      .blue_bits(blue_bits), .bright_r(bright_r), .bright_g(bright_g),
      .bright_b(bright_b), .ws2812b_out(out1), .busy(busy1),
      .pixel_idx(pidx1), .frame_done(done1)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_pair(input string tag, input logic [31:0] o0,
                             input logic [31:0] o1, input logic [31:0] exp);
      check({tag, "/grb"}, o0, exp);
      check({tag, "/rgb"}, o1, exp);
   endtask

   task automatic check_idle(input string tag);
      check_pair({tag, " ready"}, 32'(ready0), 32'(ready1), 1);
      check_pair({tag, " busy"},  32'(busy0),  32'(busy1),  0);
      check_pair({tag, " done"},  32'(done0),  32'(done1),  0);
      check_pair({tag, " out"},   32'(out0),   32'(out1),   0);
      check_pair({tag, " pidx"},  32'(pidx0),  32'(pidx1),  0);
   endtask

   // Reference: each channel byte is the brightness when the pixel's bit is
   // on, else zero; bytes go out in wire order MSB first, each bit spending
   // TB cycles of which the first T1H or T0H are high.
   function automatic void build_wave(input logic [NP-1:0] r, g, b,
                                      input logic [7:0] br, bg, bb);
      for (int o = 0; o < 2; o++) begin
         for (int p = 0; p < NP; p++) begin
            logic [7:0]  cr, cg, cb;
            logic [23:0] word;
            cr   = r[p] ? br : 8'h00;
            cg   = g[p] ? bg : 8'h00;
            cb   = b[p] ? bb : 8'h00;
            word = (o == 0) ? {cg, cr, cb} : {cr, cg, cb};
            for (int i = 0; i < 24; i++) begin
               int hi;
               hi = word[23 - i] ? T1H : T0H;
               for (int c = 0; c < TB; c++)
                  exp_wave[o][(p * 24 + i) * TB + c] = (c < hi);
            end
         end
      end
   endfunction

   // Called in the low clock phase with the DUTs idle. Offers a frame,
   // checks every wire cycle, the gap and the frame_done pulse. Returns in
   // the frame_done cycle. abort_at >= 0 pulses reset at that data cycle.
   task automatic do_frame(input logic [NP-1:0] r, g, b,
                           input logic [7:0] br, bg, bb,
                           input bit hold, input int abort_at);
      build_wave(r, g, b, br, bg, bb);
      red_bits = r;  green_bits = g;  blue_bits = b;
      bright_r = br; bright_g = bg;   bright_b = bb;
      frame_valid = 1'b1;
      $display("frame r=%b g=%b b=%b br=%h bg=%h bb=%h hold=%0d abort=%0d",
               r, g, b, br, bg, bb, hold, abort_at);
      check_pair("ready_pre", 32'(ready0), 32'(ready1), 1);
      @(posedge clk);
      #1;
      if (!hold) frame_valid = 1'b0;
      // scramble inputs right after acceptance; the shadow copy must hold
      red_bits = NP'($urandom);  green_bits = NP'($urandom);
      blue_bits = NP'($urandom); bright_r = 8'($urandom);
      bright_g = 8'($urandom);   bright_b = 8'($urandom);
      @(negedge clk);
      check_pair("accept busy",  32'(busy0),  32'(busy1),  1);
      check_pair("accept ready", 32'(ready0), 32'(ready1), 0);
      check_pair("accept done",  32'(done0),  32'(done1),  0);
      check_pair("accept out",   32'(out0),   32'(out1),   0);
      @(negedge clk);
      check_pair("load out", 32'(out0), 32'(out1), 0);
      for (int k = 0; k < DATA; k++) begin
         @(negedge clk);
         check($sformatf("wire/grb k=%0d", k), 32'(out0), 32'(exp_wave[0][k]));
         check($sformatf("wire/rgb k=%0d", k), 32'(out1), 32'(exp_wave[1][k]));
         check_pair($sformatf("pidx k=%0d", k), 32'(pidx0), 32'(pidx1), k / PIXC);
         check_pair($sformatf("busy k=%0d", k), 32'(busy0), 32'(busy1), 1);
         check_pair($sformatf("done k=%0d", k), 32'(done0), 32'(done1), 0);
         if (k == DATA / 2) begin
            red_bits = nxt_r;   green_bits = nxt_g;  blue_bits = nxt_b;
            bright_r = nxt_br;  bright_g = nxt_bg;   bright_b = nxt_bb;
         end
         if (k == abort_at) begin
            #2 rst_n = 1'b0;
            #1 check_idle("async_rst");
            repeat (3) begin
               @(negedge clk);
               check_idle("rst_held");
            end
            frame_valid = 1'b0;
            rst_n = 1'b1;
            return;
         end
      end
      for (int j = 0; j < TR; j++) begin
         @(negedge clk);
         check_pair($sformatf("gap out j=%0d", j),  32'(out0),  32'(out1),  0);
         check_pair($sformatf("gap done j=%0d", j), 32'(done0), 32'(done1), 0);
         check_pair($sformatf("gap busy j=%0d", j), 32'(busy0), 32'(busy1), 1);
         check_pair($sformatf("gap pidx j=%0d", j), 32'(pidx0), 32'(pidx1), 0);
      end
      @(negedge clk);
      check_pair("end done",  32'(done0),  32'(done1),  1);
      check_pair("end busy",  32'(busy0),  32'(busy1),  0);
      check_pair("end ready", 32'(ready0), 32'(ready1), 1);
      check_pair("end out",   32'(out0),   32'(out1),   0);
   endtask

   initial begin
      logic [NP-1:0] ar, ag, ab;
      logic [7:0]    abr, abg, abb;

      rst_n = 1'b1;
      frame_valid = 1'b0;
      red_bits = '0; green_bits = '0; blue_bits = '0;
      bright_r = '0; bright_g = '0;   bright_b = '0;
      nxt_r = '0; nxt_g = '0; nxt_b = '0;
      nxt_br = '0; nxt_bg = '0; nxt_bb = '0;

      // reset asserted between clock edges must act at once
      #12 rst_n = 1'b0;
      #1 check_idle("reset_async");
      repeat (2) @(negedge clk);
      check_idle("reset_held");
      rst_n = 1'b1;
      @(negedge clk);
      check_idle("after_release");

      // GRB reference frame
      nxt_r = NP'($urandom); nxt_br = 8'($urandom);
      do_frame(2'b01, 2'b00, 2'b10, 8'hFF, 8'hFF, 8'hFF, 1'b0, -1);

      // red only at A5 on both pixels
      do_frame(2'b11, 2'b00, 2'b00, 8'hA5, 8'h00, 8'h00, 1'b0, -1);

      // frame_valid held high; second frame takes the values changed mid-frame
      ar = NP'($urandom); ag = NP'($urandom); ab = NP'($urandom);
      abr = 8'($urandom); abg = 8'($urandom); abb = 8'($urandom);
      nxt_r = NP'($urandom); nxt_g = NP'($urandom); nxt_b = NP'($urandom);
      nxt_br = 8'($urandom); nxt_bg = 8'($urandom); nxt_bb = 8'($urandom);
      do_frame(ar, ag, ab, abr, abg, abb, 1'b1, -1);
      do_frame(nxt_r, nxt_g, nxt_b, nxt_br, nxt_bg, nxt_bb, 1'b0, -1);

      // all bits off
      do_frame(2'b00, 2'b00, 2'b00, 8'($urandom), 8'($urandom), 8'($urandom),
               1'b0, -1);

      // bits on but zero brightness
      do_frame(2'b11, 2'b11, 2'b11, 8'h00, 8'h00, 8'h00, 1'b0, -1);

      // reset during pixel 1 bit 5 (first cycle of the bit, wire high)
      do_frame(NP'($urandom), NP'($urandom), NP'($urandom),
               8'($urandom), 8'($urandom), 8'($urandom), 1'b0, PIXC + 5 * TB);
      do_frame(NP'($urandom), NP'($urandom), NP'($urandom),
               8'($urandom), 8'($urandom), 8'($urandom), 1'b0, -1);

      // a few more random frames
      repeat (2) begin
         nxt_r = NP'($urandom); nxt_br = 8'($urandom);
         do_frame(NP'($urandom), NP'($urandom), NP'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom), 1'b0, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
